// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// waits on a memory-ready handshake with timeout, flags illegal encodings and counts retirements.
module mips_multicycle_control #(
  parameter int MEM_WAIT_EN    = 1,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             destination_indicator,
  output logic             srcA_sel,
  output logic [1:0]       mux4selector,
  output logic [3:0]       ALUControl,
  output logic             illegal_instr,
  output logic             timeout_err,
  output logic [CNT_W-1:0] retired_count,
  output logic [3:0]       state_out
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_START     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_I    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_WB_ALU    = 4'd8,
    S_WB_MEM    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_ILLEGAL   = 4'd12,
    S_TIMEOUT   = 4'd13
  } state_t;

  // fetch/branch mark states whose pc_write/ir_write also depend on live inputs
  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       dest;
    logic       srca;
    logic [1:0] srcb;
    logic [3:0] alu;
    logic       fetch;
    logic       branch;
  } ctrl_t;

  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   return 4'd3;
      6'h24:   return 4'd5;
      6'h25:   return 4'd6;
      6'h00:   return 4'd8;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [3:0] i_alu(input logic [5:0] op);
    case (op)
      6'h0C:   return 4'd5;
      6'h0D:   return 4'd6;
      default: return 4'd2;
    endcase
  endfunction

  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        case (fn)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h00: return S_EXEC_R;
          default:                           return S_ILLEGAL;
        endcase
      end
      6'h08, 6'h0C, 6'h0D: return S_EXEC_I;
      6'h23, 6'h2B:        return S_MEM_ADDR;
      6'h04, 6'h05:        return S_BRANCH;
      6'h02:               return S_JUMP;
      default:             return S_ILLEGAL;
    endcase
  endfunction

  function automatic ctrl_t moore_ctrl(input state_t st, input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c     = '0;
    c.alu = 4'd2;
    case (st)
      S_FETCH:     begin c.mem_read = 1'b1; c.srcb = 2'd1; c.fetch = 1'b1; end
      S_DECODE:    c.srcb = 2'd3;
      S_EXEC_R:    begin c.srca = 1'b1; c.srcb = 2'd0; c.alu = r_alu(fn); end
      S_EXEC_I:    begin c.srca = 1'b1; c.srcb = 2'd2; c.alu = i_alu(op); end
      S_MEM_ADDR:  begin c.srca = 1'b1; c.srcb = 2'd2; end
      S_MEM_READ:  c.mem_read = 1'b1;
      S_MEM_WRITE: c.mem_write = 1'b1;
      S_WB_ALU:    begin c.reg_write = 1'b1; c.dest = (op == 6'h00); end
      S_WB_MEM:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_BRANCH:    begin c.srca = 1'b1; c.srcb = 2'd0; c.alu = 4'd3; c.pc_src = 2'd1; c.branch = 1'b1; end
      S_JUMP:      begin c.pc_src = 2'd2; c.pc_write = 1'b1; end
      default:     c.alu = 4'd2;
    endcase
    return c;
  endfunction

  state_t              state_r, state_nxt_s;
  ctrl_t               ctrl_r;
  logic [WAIT_W-1:0]   wait_cnt_r, wait_cnt_nxt_s;
  logic                illegal_r, timeout_r;
  logic [CNT_W-1:0]    retired_r;
  logic                ready_s, stall_timeout_s, wait_state_s, retire_s, br_taken_s;

  assign ready_s         = (MEM_WAIT_EN == 0) ? 1'b1 : mem_ready;
  assign stall_timeout_s = !ready_s && (wait_cnt_r == WAIT_LAST);
  assign wait_state_s    = (state_r == S_FETCH) || (state_r == S_MEM_READ) || (state_r == S_MEM_WRITE);
  assign br_taken_s      = (opcode == 6'h05) ? ~zero : zero;

  // Next-state selection; ready in the last allowed stall cycle beats the timeout
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_START:     state_nxt_s = S_FETCH;
      S_FETCH:     if (ready_s) state_nxt_s = S_DECODE;
                   else if (stall_timeout_s) state_nxt_s = S_TIMEOUT;
                   else state_nxt_s = S_FETCH;
      S_DECODE:    state_nxt_s = decode_next(opcode, funct);
      S_EXEC_R:    state_nxt_s = S_WB_ALU;
      S_EXEC_I:    state_nxt_s = S_WB_ALU;
      S_MEM_ADDR:  if (opcode == 6'h23) state_nxt_s = S_MEM_READ;
                   else state_nxt_s = S_MEM_WRITE;
      S_MEM_READ:  if (ready_s) state_nxt_s = S_WB_MEM;
                   else if (stall_timeout_s) state_nxt_s = S_TIMEOUT;
                   else state_nxt_s = S_MEM_READ;
      S_MEM_WRITE: if (ready_s) state_nxt_s = S_FETCH;
                   else if (stall_timeout_s) state_nxt_s = S_TIMEOUT;
                   else state_nxt_s = S_MEM_WRITE;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_nxt_s = S_FETCH;
      default:     state_nxt_s = state_r;
    endcase
  end

  // Stall counter only runs while a memory state keeps waiting in place
  always_comb begin
    wait_cnt_nxt_s = '0;
    if (wait_state_s && !ready_s && (state_nxt_s == state_r)) wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
    else wait_cnt_nxt_s = '0;
  end

  // Retirement happens on the edge from a completing state back to FETCH
  always_comb begin
    retire_s = 1'b0;
    case (state_r)
      S_MEM_WRITE, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: retire_s = (state_nxt_s == S_FETCH);
      default: retire_s = 1'b0;
    endcase
  end

  // State, Moore outputs of the upcoming state, sticky flags and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_START;
      ctrl_r     <= moore_ctrl(S_START, opcode, funct);
      wait_cnt_r <= '0;
      illegal_r  <= 1'b0;
      timeout_r  <= 1'b0;
      retired_r  <= '0;
    end else begin
      state_r    <= state_nxt_s;
      ctrl_r     <= moore_ctrl(state_nxt_s, opcode, funct);
      wait_cnt_r <= wait_cnt_nxt_s;
      illegal_r  <= illegal_r | (state_nxt_s == S_ILLEGAL);
      timeout_r  <= timeout_r | (state_nxt_s == S_TIMEOUT);
      if (retire_s) retired_r <= retired_r + CNT_W'(1);
      else retired_r <= retired_r;
    end
  end

  assign pc_write              = ctrl_r.pc_write | (ctrl_r.fetch & ready_s) | (ctrl_r.branch & br_taken_s);
  assign ir_write              = ctrl_r.fetch & ready_s;
  assign pc_src                = ctrl_r.pc_src;
  assign mem_read              = ctrl_r.mem_read;
  assign mem_write             = ctrl_r.mem_write;
  assign reg_write             = ctrl_r.reg_write;
  assign mem_to_reg            = ctrl_r.mem_to_reg;
  assign destination_indicator = ctrl_r.dest;
  assign srcA_sel              = ctrl_r.srca;
  assign mux4selector          = ctrl_r.srcb;
  assign ALUControl            = ctrl_r.alu;
  assign illegal_instr         = illegal_r;
  assign timeout_err           = timeout_r;
  assign retired_count         = retired_r;
  assign state_out             = state_r;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: per-instruction expected step tables played against
// a waiting instance (CNT_W=4) and a no-wait instance (MEM_WAIT_EN=0).
module tb_mips_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw, mr, mw, rw, m2r, dst, sa;
    logic [1:0] sb;
    logic [3:0] alu;
    logic       ill, tmo;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic rdy;
    logic z;
  } step_t;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_J = 5, K_ILL = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = 6'h00, funct = 6'h00;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic use_b = 1'b0;

  logic pcw_a, irw_a, mr_a, mw_a, rw_a, m2r_a, dst_a, sa_a, ill_a, tmo_a;
  logic [1:0] pcs_a, sb_a;
  logic [3:0] alu_a, st_a;
  logic [3:0] rc_a;
  logic pcw_b, irw_b, mr_b, mw_b, rw_b, m2r_b, dst_b, sa_b, ill_b, tmo_b;
  logic [1:0] pcs_b, sb_b;
  logic [3:0] alu_b, st_b;
  logic [15:0] rc_b;
  ctl_t obs_a, obs_b;

  int tests_run = 0;
  int tests_failed = 0;
  int model_cnt = 0;
  step_t q[$];

  always #5 clk = ~clk;

  mips_multicycle_control #(.MEM_WAIT_EN(1), .TIMEOUT_CYCLES(16), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pcw_a), .pc_src(pcs_a), .ir_write(irw_a), .mem_read(mr_a), .mem_write(mw_a),
    .reg_write(rw_a), .mem_to_reg(m2r_a), .destination_indicator(dst_a), .srcA_sel(sa_a),
    .mux4selector(sb_a), .ALUControl(alu_a), .illegal_instr(ill_a), .timeout_err(tmo_a),
    .retired_count(rc_a), .state_out(st_a));

  mips_multicycle_control #(.MEM_WAIT_EN(0), .TIMEOUT_CYCLES(16), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pcw_b), .pc_src(pcs_b), .ir_write(irw_b), .mem_read(mr_b), .mem_write(mw_b),
    .reg_write(rw_b), .mem_to_reg(m2r_b), .destination_indicator(dst_b), .srcA_sel(sa_b),
    .mux4selector(sb_b), .ALUControl(alu_b), .illegal_instr(ill_b), .timeout_err(tmo_b),
    .retired_count(rc_b), .state_out(st_b));

  assign obs_a = {st_a, pcw_a, pcs_a, irw_a, mr_a, mw_a, rw_a, m2r_a, dst_a, sa_a, sb_a, alu_a, ill_a, tmo_a};
  assign obs_b = {st_b, pcw_b, pcs_b, irw_b, mr_b, mw_b, rw_b, m2r_b, dst_b, sa_b, sb_b, alu_b, ill_b, tmo_b};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic ctl_t base(input logic [3:0] st);
    ctl_t c;
    c     = '0;
    c.st  = st;
    c.alu = 4'd2;
    return c;
  endfunction

  function automatic int klass(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:               return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h00}) ? K_R : K_ILL;
      6'h08, 6'h0C, 6'h0D: return K_I;
      6'h23:               return K_LW;
      6'h2B:               return K_SW;
      6'h04, 6'h05:        return K_BR;
      6'h02:               return K_J;
      default:             return K_ILL;
    endcase
  endfunction

  // ALU operation named by the instruction mnemonic: add-like 2, sub 3, and 5, or 6, sll 8
  function automatic logic [3:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h22:   return 4'd3;
        6'h24:   return 4'd5;
        6'h25:   return 4'd6;
        6'h00:   return 4'd8;
        default: return 4'd2;
      endcase
    end else if (op == 6'h0C) return 4'd5;
    else if (op == 6'h0D) return 4'd6;
    else return 4'd2;
  endfunction

  task automatic push(input ctl_t c, input logic r, input logic z);
    step_t s;
    s.c = c; s.rdy = r; s.z = z;
    q.push_back(s);
  endtask

  task automatic push_fetch(input int fst, input logic z);
    ctl_t c;
    for (int i = 0; i < fst; i++) begin
      c = base(4'd1); c.mr = 1'b1; c.sb = 2'd1;
      push(c, 1'b0, z);
    end
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, starting in FETCH
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fst, input int mst, input logic z);
    ctl_t c;
    push_fetch(fst, z);
    c = base(4'd1); c.mr = 1'b1; c.sb = 2'd1; c.irw = 1'b1; c.pcw = 1'b1; push(c, 1'b1, z);
    c = base(4'd2); c.sb = 2'd3; push(c, rnd(), z);
    case (klass(op, fn))
      K_R: begin
        c = base(4'd3); c.sa = 1'b1; c.alu = alu_of(op, fn); push(c, rnd(), z);
        c = base(4'd8); c.rw = 1'b1; c.dst = 1'b1; push(c, rnd(), z);
      end
      K_I: begin
        c = base(4'd4); c.sa = 1'b1; c.sb = 2'd2; c.alu = alu_of(op, fn); push(c, rnd(), z);
        c = base(4'd8); c.rw = 1'b1; push(c, rnd(), z);
      end
      K_LW: begin
        c = base(4'd5); c.sa = 1'b1; c.sb = 2'd2; push(c, rnd(), z);
        c = base(4'd6); c.mr = 1'b1;
        for (int i = 0; i < mst; i++) push(c, 1'b0, z);
        push(c, 1'b1, z);
        c = base(4'd9); c.rw = 1'b1; c.m2r = 1'b1; push(c, rnd(), z);
      end
      K_SW: begin
        c = base(4'd5); c.sa = 1'b1; c.sb = 2'd2; push(c, rnd(), z);
        c = base(4'd7); c.mw = 1'b1;
        for (int i = 0; i < mst; i++) push(c, 1'b0, z);
        push(c, 1'b1, z);
      end
      K_BR: begin
        c = base(4'd10); c.sa = 1'b1; c.alu = 4'd3; c.pcs = 2'd1;
        c.pcw = (op == 6'h05) ? ~z : z;
        push(c, rnd(), z);
      end
      K_J: begin
        c = base(4'd11); c.pcs = 2'd2; c.pcw = 1'b1; push(c, rnd(), z);
      end
      default: begin
        c = base(4'd12); c.ill = 1'b1;
        for (int i = 0; i < 4; i++) push(c, rnd(), rnd());
      end
    endcase
  endtask

  task automatic play(input int n);
    step_t s;
    int k;
    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      s = q.pop_front();
      k++;
      mem_ready = use_b ? 1'b0 : s.rdy;
      zero = s.z;
      @(negedge clk);
      check($sformatf("ctl_state%0d", s.c.st), 64'(use_b ? obs_b : obs_a), 64'(s.c));
      @(posedge clk); #1;
    end
    q.delete();
  endtask

  task automatic check_count(input string tag);
    logic [63:0] got, exp;
    got = use_b ? 64'(rc_b) : 64'(rc_a);
    exp = use_b ? 64'(model_cnt % 65536) : 64'(model_cnt % 16);
    check(tag, got, exp);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fst, input int mst, input logic z);
    opcode = op; funct = fn;
    build(op, fn, fst, mst, z);
    play(-1);
    if (klass(op, fn) != K_ILL) model_cnt++;
    check_count("retired");
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ready = rnd();
    @(posedge clk); #1;
    reset = 1'b0;
    model_cnt = 0;
    @(negedge clk);
    check("reset_ctl", 64'(use_b ? obs_b : obs_a), 64'(base(4'd0)));
    check_count("reset_cnt");
    @(posedge clk); #1;
  endtask

  logic [5:0] ops [13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
  logic [5:0] fns [13] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1);
  end

  initial begin
    ctl_t c;
    int idx;
    logic [5:0] fn;

    // Directed: or, lw with three read stalls, beq/bne with zero set
    do_reset();
    run_instr(6'h00, 6'h25, 0, 0, 1'b0);
    run_instr(6'h23, 6'h11, 0, 3, 1'b0);
    check("no_timeout", 64'(tmo_a), 64'd0);
    run_instr(6'h04, 6'h00, 0, 0, 1'b1);
    run_instr(6'h05, 6'h00, 0, 0, 1'b1);
    run_instr(6'h2B, 6'h00, 2, 2, 1'b0);

    // Illegal opcode and illegal funct: sticky, strobes quiet until reset
    run_instr(6'h3F, 6'h00, 0, 0, 1'b0);
    do_reset();
    run_instr(6'h00, 6'h08, 1, 0, 1'b0);
    do_reset();

    // Timeout on the 16th consecutive fetch stall
    opcode = 6'h08;
    push_fetch(16, 1'b0);
    c = base(4'd13); c.tmo = 1'b1;
    for (int i = 0; i < 3; i++) push(c, rnd(), 1'b0);
    play(-1);
    do_reset();
    // Ready on the 16th cycle wins, in fetch and in a read
    run_instr(6'h08, 6'h00, 15, 0, 1'b0);
    run_instr(6'h23, 6'h00, 0, 15, 1'b0);
    run_instr(6'h2B, 6'h00, 0, 15, 1'b0);
    check("no_timeout_15", 64'(tmo_a), 64'd0);

    // Retire counter wrap with 4-bit width over 17 jumps
    do_reset();
    for (int i = 0; i < 17; i++) run_instr(6'h02, 6'($urandom_range(63, 0)), 0, 0, rnd());

    // Randomised legal program
    do_reset();
    for (int i = 0; i < 60; i++) begin
      idx = $urandom_range(12, 0);
      fn = (ops[idx] == 6'h00) ? fns[idx] : 6'($urandom_range(63, 0));
      run_instr(ops[idx], fn, rnd() ? $urandom_range(3, 0) : 0, $urandom_range(3, 0), rnd());
    end

    // Reset in the middle of a stalled read
    opcode = 6'h23; funct = 6'h00;
    build(6'h23, 6'h00, 0, 5, 1'b0);
    play(6);
    do_reset();
    run_instr(6'h00, 6'h22, 0, 0, 1'b0);

    // No-wait instance: mem_ready held low is ignored
    use_b = 1'b1;
    do_reset();
    run_instr(6'h23, 6'h00, 0, 0, 1'b0);
    run_instr(6'h2B, 6'h00, 0, 0, 1'b0);
    run_instr(6'h00, 6'h20, 0, 0, 1'b0);
    run_instr(6'h04, 6'h00, 0, 0, 1'b0);
    run_instr(6'h0D, 6'h00, 0, 0, 1'b0);
    check("b_no_timeout", 64'(tmo_b), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
